// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the
// baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Write request from the receive FSM into the byte buffer.
  typedef struct packed {
    logic                 vld;
    logic [DATA_BITS-1:0] data;
  } rx_byte_t;

  // System clocks per oversample tick.
  function automatic int uart_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small power-of-two receive buffer; head byte is read straight from storage,
// a push into a full buffer is only accepted when a pop frees a slot that cycle.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  rx_byte_t             wr,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic                 empty,
  output logic                 overrun
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_BITS-1:0] mem;
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [AW:0]                     count;
  logic                            full, pop_ok, push_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = wr.vld && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= wr.vld && full && !pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; dout is gated to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr.data;
  end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling on a tick enable, mid-bit sampling,
// framing-error detection and a small output buffer with valid/ready drain.
module uart_rx_os import uart_pkg::*; #(
  parameter int CLK_FREQ   = 1600000,
  parameter int BAUD       = 10000,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int             DIV      = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int             DCW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam int             OSW      = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
  localparam int             BCW      = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  logic                 rx_meta, rxs;
  logic [DCW-1:0]       div_cnt;
  logic                 tick;
  rx_state_e            state, state_n;
  logic [OSW-1:0]       os_cnt, os_n;
  logic [BCW-1:0]       bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic                 push, fe_set, fifo_empty;
  rx_byte_t             wr_req;

  // Synchroniser resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_n;
      bit_cnt   <= bit_n;
      shreg     <= sh_n;
      frame_err <= fe_set;
    end
  end

  always_comb begin
    state_n = state;
    os_n    = os_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    push    = 1'b0;
    fe_set  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_n = START;
            os_n    = '0;
          end
        end
        START: begin
          // Half a bit in: still low means a real start bit, else a glitch.
          if (os_cnt == OS_MID) begin
            os_n    = '0;
            bit_n   = '0;
            state_n = rxs ? IDLE : DATA;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        DATA: begin
          if (os_cnt == OS_LAST) begin
            sh_n  = {rxs, shreg[DATA_BITS-1:1]};
            os_n  = '0;
            bit_n = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state_n = STOP;
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        STOP: begin
          if (os_cnt == OS_LAST) begin
            os_n = '0;
            if (rxs) begin
              push    = 1'b1;
              state_n = IDLE;
            end else begin
              fe_set  = 1'b1;
              state_n = WAIT_IDLE;
            end
          end else begin
            os_n = os_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign wr_req.vld  = push;
  assign wr_req.data = shreg;
  assign dout_valid  = !fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr_req),
    .pop     (dout_ready),
    .dout    (dout),
    .empty   (fifo_empty),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at default parameters (one bit = 160 clk).
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst, rx, dout_ready;
  logic [7:0] dout;
  logic       dout_valid, frame_err, overrun, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vld_cyc = 0;
  int rise_cyc = 0;
  logic vld_q = 1'b0;
  logic [7:0] got[$];

  int frame_cyc, b0, f0, ov0, f1, d_lat;
  logic [7:0] v;
  logic [7:0] exp5 [4];

  uart_rx_os dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle; pops happen on the following rising edge.
  always @(negedge clk) begin
    if (dout_valid && dout_ready) got.push_back(dout);
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (dout_valid) vld_cyc <= vld_cyc + 1;
    if (dout_valid && !vld_q) rise_cyc <= cyc;
    vld_q <= dout_valid;
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    frame_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      cyc_wait(160);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    dout_ready = 1'b1;
    cyc_wait(5);
    rst = 1'b0;
    cyc_wait(2);
    check("rst_dout", dout, 8'h00);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // 1: single good byte, drained immediately
    b0 = got.size();
    send_frame(8'hA5, 1'b1);
    check("t1_busy_after_stop", busy, 1'b0);
    cyc_wait(20);
    check("t1_count", got.size() - b0, 1);
    check("t1_data", got_at(b0), 8'hA5);
    check("t1_valid_cycles", vld_cyc, 1);
    check("t1_no_frame_err", fe_cnt, 0);

    // 2: stop bit low, then recovery
    b0 = got.size();
    send_frame(8'h3C, 1'b0);
    check("t2_wait_idle_busy", busy, 1'b1);
    check("t2_frame_err", fe_cnt, 1);
    rx = 1'b1;
    cyc_wait(160);
    check("t2_back_idle", busy, 1'b0);
    check("t2_no_byte", got.size() - b0, 0);
    check("t2_no_valid", dout_valid, 1'b0);
    send_frame(8'h55, 1'b1);
    cyc_wait(20);
    check("t2_recover_count", got.size() - b0, 1);
    check("t2_recover_data", got_at(b0), 8'h55);
    check("t2_single_frame_err", fe_cnt, 1);

    // 3: short low glitch
    b0 = got.size();
    rx = 1'b0;
    cyc_wait(30);
    check("t3_start_seen", busy, 1'b1);
    cyc_wait(10);
    rx = 1'b1;
    cyc_wait(200);
    check("t3_idle", busy, 1'b0);
    check("t3_no_byte", got.size() - b0, 0);
    check("t3_no_frame_err", fe_cnt, 1);
    check("t3_no_valid", dout_valid, 1'b0);

    // 4: fill with consumer stalled, fifth byte overruns
    dout_ready = 1'b0;
    b0 = got.size();
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    check("t4_no_overrun_yet", ov_cnt - ov0, 0);
    check("t4_valid_full", dout_valid, 1'b1);
    check("t4_head", dout, 8'h01);
    send_frame(8'h05, 1'b1);
    cyc_wait(20);
    check("t4_overrun_once", ov_cnt - ov0, 1);
    check("t4_head_kept", dout, 8'h01);
    dout_ready = 1'b1;
    cyc_wait(10);
    check("t4_drain_count", got.size() - b0, 4);
    for (int i = 0; i < 4; i++) check("t4_drain_data", got_at(b0 + i), 32'(i + 1));
    check("t4_empty", dout_valid, 1'b0);
    dout_ready = 1'b0;

    // 5: push into full buffer on the same edge as a single pop
    b0 = got.size();
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    f1 = frame_cyc;
    d_lat = rise_cyc - f1;
    check("t5_latency_window", (d_lat >= 1523 && d_lat <= 1532), 1'b1);
    if (d_lat < 1523 || d_lat > 1532) d_lat = 1527;
    send_frame(8'h12, 1'b1);
    send_frame(8'h13, 1'b1);
    send_frame(8'h14, 1'b1);
    check("t5_full_head", dout, 8'h11);
    fork
      send_frame(8'h15, 1'b1);
      begin
        cyc_wait(d_lat - 1);
        dout_ready = 1'b1;
        cyc_wait(1);
        dout_ready = 1'b0;
      end
    join
    cyc_wait(20);
    check("t5_no_overrun", ov_cnt - ov0, 0);
    check("t5_one_pop", got.size() - b0, 1);
    check("t5_popped", got_at(b0), 8'h11);
    check("t5_new_head", dout, 8'h12);
    dout_ready = 1'b1;
    cyc_wait(10);
    check("t5_drain_count", got.size() - b0, 5);
    exp5[0] = 8'h12; exp5[1] = 8'h13; exp5[2] = 8'h14; exp5[3] = 8'h15;
    for (int i = 0; i < 4; i++) check("t5_drain_data", got_at(b0 + 1 + i), exp5[i]);
    check("t5_empty", dout_valid, 1'b0);

    // 6: reset in the middle of bit 4, then a clean frame
    b0 = got.size();
    f0 = fe_cnt;
    v = 8'h9E;
    rx = 1'b0;
    cyc_wait(160);
    for (int i = 0; i < 4; i++) begin
      rx = v[i];
      cyc_wait(160);
    end
    rx = v[4];
    cyc_wait(80);
    rst = 1'b1;
    cyc_wait(1);
    rst = 1'b0;
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_valid", dout_valid, 1'b0);
    rx = 1'b1;
    cyc_wait(320);
    check("t6_no_partial", got.size() - b0, 0);
    check("t6_no_flag", fe_cnt - f0, 0);
    send_frame(8'h9E, 1'b1);
    cyc_wait(20);
    check("t6_count", got.size() - b0, 1);
    check("t6_data", got_at(b0), 8'h9E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
